// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search sequencer: controller mode codes,
// the sequencer state encoding and the plaintext character test.
package rc4_pkg;

    localparam logic [5:0] MODE_IDLE    = 6'b000_000;
    localparam logic [5:0] MODE_INIT    = 6'b001_000;
    localparam logic [5:0] MODE_SHUFFLE = 6'b010_000;
    localparam logic [5:0] MODE_DECRYPT = 6'b011_000;

    // Finish-bus bit owned by each run phase.
    localparam int FIN_INIT    = 0;
    localparam int FIN_SHUFFLE = 1;
    localparam int FIN_DECRYPT = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_GAP1,
        ST_SHUF,
        ST_GAP2,
        ST_DECR,
        ST_GAP3,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    // A decrypted byte counts as plaintext when it is a space or a lowercase letter.
    function automatic logic is_plain_char(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Controller mode presented while the sequencer sits in a given state.
    function automatic logic [5:0] mode_of(input seq_state_t s);
        case (s)
            ST_INIT: return MODE_INIT;
            ST_SHUF: return MODE_SHUFFLE;
            ST_DECR: return MODE_DECRYPT;
            default: return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/msg_checker.sv
// Streams the result RAM and tests every byte for plaintext validity.
// While i_go is high the read address walks 0..2**LOG_LEN-1; data returns one
// cycle later and is tested as it arrives. o_fail pulses on the first bad byte,
// o_pass pulses when the last byte arrives valid. Dropping i_go rewinds the
// stream and discards any read still in flight.
module msg_checker
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH = 8,
    parameter int LOG_LEN   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_go,
    input  logic [RAM_WIDTH-1:0] i_rdata,
    output logic [LOG_LEN-1:0]   o_raddr,
    output logic                 o_pass,
    output logic                 o_fail
);

    localparam logic [LOG_LEN-1:0] ADDR_LAST = {LOG_LEN{1'b1}};

    logic [LOG_LEN-1:0] r_addr;
    logic               r_issued_all;
    logic               r_vld;
    logic               r_last;
    logic               w_byte_ok;

    // Address generator plus a one-stage tag pipeline aligned with RAM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_issued_all <= 1'b0;
            r_vld        <= 1'b0;
            r_last       <= 1'b0;
        end else if (!i_go) begin
            r_addr       <= '0;
            r_issued_all <= 1'b0;
            r_vld        <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_vld  <= !r_issued_all;
            r_last <= !r_issued_all && (r_addr == ADDR_LAST);
            if (r_addr == ADDR_LAST) begin
                r_issued_all <= 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign w_byte_ok = is_plain_char(i_rdata[7:0]);
    assign o_raddr   = r_addr;
    assign o_fail    = i_go && r_vld && !w_byte_ok;
    assign o_pass    = i_go && r_vld && r_last && w_byte_ok;

endmodule

// File: rtl/rc4_key_sequencer.sv
// Brute-force key sequencer for the RC4 decryption core. For each candidate key
// it runs the RAM controller through init, shuffle and decrypt, then scans the
// result RAM for plaintext. Stops on the first valid message or after KEY_MAX.
// Optional feature: define RC4_SEQ_TIMEOUT_EN to build a per-phase watchdog that
// aborts the search with error=1 after TIMEOUT_CYCLES cycles in one run phase.
module rc4_key_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH          = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int NUM_DEVICES        = 3,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MAX = 24'h3FFFFF,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    output logic [5:0]                            mode,
    output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  key,
    input  logic [NUM_DEVICES-1:0]                finish_bus,
    output logic [MESSAGE_LOG_LENGTH-1:0]         rAddr,
    input  logic [RAM_WIDTH-1:0]                  rOut,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  found,
    output logic                                  error
);

    localparam int KEY_BITS = KEY_LENGTH * RAM_WIDTH;

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic                r_armed;
    logic [5:0]          r_mode;
    logic [KEY_BITS-1:0] r_key;
    logic                r_busy;
    logic                r_done;
    logic                r_found;

    logic                w_run;
    logic                w_fin;
    logic                w_restart;
    logic                w_timeout;
    logic                w_chk_go;
    logic                w_chk_pass;
    logic                w_chk_fail;

    logic [5:0]          w_mode_next;
    logic [KEY_BITS-1:0] w_key_next;
    logic                w_busy_next;
    logic                w_done_next;
    logic                w_found_next;

    assign w_chk_go = (r_state == ST_CHECK);

    msg_checker #(
        .RAM_WIDTH (RAM_WIDTH),
        .LOG_LEN   (MESSAGE_LOG_LENGTH)
    ) u_msg_checker (
        .clk     (clk),
        .reset   (reset),
        .i_go    (w_chk_go),
        .i_rdata (rOut),
        .o_raddr (rAddr),
        .o_pass  (w_chk_pass),
        .o_fail  (w_chk_fail)
    );

    // State register and registered outputs, all loaded from the next-state view.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_mode  <= MODE_IDLE;
            r_key   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_found <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // The arm flag restarts on every state change; it sets once the
            // owning finish bit has been seen low, so a stale high is ignored.
            if (w_next_state != r_state) begin
                r_armed <= 1'b0;
            end else if (w_run && !w_fin) begin
                r_armed <= 1'b1;
            end
            r_mode  <= w_mode_next;
            r_key   <= w_key_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_found <= w_found_next;
        end
    end

    // Next-state decision, including the phase handshake and the CHECK outcome.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_run        = 1'b0;
        w_fin        = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                w_run = 1'b1;
                w_fin = finish_bus[FIN_INIT];
                if (w_fin && r_armed) w_next_state = ST_GAP1;
            end
            ST_GAP1: w_next_state = ST_SHUF;
            ST_SHUF: begin
                w_run = 1'b1;
                w_fin = finish_bus[FIN_SHUFFLE];
                if (w_fin && r_armed) w_next_state = ST_GAP2;
            end
            ST_GAP2: w_next_state = ST_DECR;
            ST_DECR: begin
                w_run = 1'b1;
                w_fin = finish_bus[FIN_DECRYPT];
                if (w_fin && r_armed) w_next_state = ST_GAP3;
            end
            ST_GAP3: w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_chk_fail) begin
                    w_next_state = ST_NEXT;
                end else if (w_chk_pass) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_NEXT: begin
                w_next_state = (r_key == KEY_MAX) ? ST_DONE : ST_INIT;
            end
            ST_DONE: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_next_state = ST_INIT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        // The watchdog only acts when the phase is not already leaving on its own.
        if (w_timeout && (w_next_state == r_state)) begin
            w_next_state = ST_DONE;
        end
    end

    // Output values that the registers take on entry to the next state.
    always_comb begin
        w_mode_next  = mode_of(w_next_state);
        w_busy_next  = !((w_next_state == ST_IDLE) || (w_next_state == ST_DONE));
        w_done_next  = (w_next_state == ST_DONE);
        w_found_next = (w_next_state == ST_DONE) &&
                       ((r_state == ST_DONE) ? r_found : (r_state == ST_CHECK));
        w_key_next   = r_key;
        if (w_restart) begin
            w_key_next = '0;
        end else if ((r_state == ST_NEXT) && (w_next_state == ST_INIT)) begin
            w_key_next = r_key + 1'b1;
        end
    end

`ifdef RC4_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;

    // Per-phase cycle counter; it idles at zero outside run states, so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_run) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = w_run && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Error flag set by a watchdog abort and held through DONE until the next start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (w_next_state == ST_DONE) &&
                       ((r_state == ST_DONE) ? r_error : w_timeout);
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    assign mode  = r_mode;
    assign key   = r_key;
    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;

endmodule

// File: tb/tb_rc4_key_sequencer.sv
// Directed bench for rc4_key_sequencer with behavioural init/shuffle/decrypt
// devices (finish 3 cycles after their mode appears) and a result-RAM model
// whose content depends on the current candidate key.
`timescale 1ns/1ps
module tb_rc4_key_sequencer;

    localparam logic [5:0] M_IDLE = 6'b000_000;
    localparam logic [5:0] M_INIT = 6'b001_000;
    localparam logic [5:0] M_SHUF = 6'b010_000;
    localparam logic [5:0] M_DECR = 6'b011_000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [5:0]       mode;
    logic [2:0][7:0]  key_w;
    logic [2:0]       fin = 3'b111;
    logic [4:0]       raddr;
    logic [7:0]       rout = 8'h00;
    logic             busy, done, found, error;

    logic [23:0]      key_flat;
    logic [23:0]      win_key = 24'h000002;
    logic             decr_hang = 1'b0;
    int               dcnt [3];
    int               total = 0;
    int               bad = 0;
    int               gap_viol = 0;
    logic [5:0]       prev_mode = 6'b0;

    assign key_flat = key_w;

    rc4_key_sequencer #(
        .KEY_MAX        (24'h000003),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .key        (key_w),
        .finish_bus (fin),
        .rAddr      (raddr),
        .rOut       (rout),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .error      (error)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dev_code(input int d);
        case (d)
            0: return M_INIT;
            1: return M_SHUF;
            default: return M_DECR;
        endcase
    endfunction

    // Devices: finish drops on the first cycle their mode is seen, rises 3 cycles in, then holds.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                fin[d]  <= 1'b1;
                dcnt[d] <= 0;
            end else if (mode == dev_code(d)) begin
                if (dcnt[d] == 0) fin[d] <= 1'b0;
                if ((dcnt[d] + 1 >= 3) && !((d == 2) && decr_hang)) fin[d] <= 1'b1;
                dcnt[d] <= dcnt[d] + 1;
            end else begin
                dcnt[d] <= 0;
            end
        end
    end

    // Winning key holds space/a..z/z-boundary text; other keys carry 8'h7B at index 5.
    function automatic logic [7:0] msg_byte(input logic [23:0] k, input logic [4:0] a);
        if (k == win_key) begin
            if (a == 5'd0)  return 8'h20;
            if (a == 5'd31) return 8'h7A;
            return (a < 5'd26) ? (8'h61 + {3'b000, a}) : 8'h20;
        end
        return (a == 5'd5) ? 8'h7B : 8'h61;
    endfunction

    always @(posedge clk) rout <= msg_byte(key_flat, raddr);

    // A run mode must always be preceded by at least one IDLE cycle.
    always @(negedge clk) begin
        if ((mode != M_IDLE) && (prev_mode != M_IDLE) && (mode != prev_mode)) gap_viol++;
        prev_mode <= mode;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts consecutive cycles (sampled on negedges) that mode stays at code.
    task automatic measure(input logic [5:0] code, output int len);
        len = 0;
        while ((mode == code) && (len < 200)) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && (n < limit)) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int len;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mode",  {26'b0, mode}, M_IDLE);
        check("rst_key",   key_flat, 0);
        check("rst_raddr", raddr, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_found", found, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start", {26'b0, mode}, M_IDLE);

        // Search that succeeds at key 2; finish bits are stale-high at first entry.
        pulse_start();
        check("start_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            check("init_mode", {26'b0, mode}, M_INIT);
            check("init_key",  key_flat, k);
            measure(M_INIT, len); check("init_len", len, 4);
            measure(M_IDLE, len); check("gap1_len", len, 1);
            check("shuf_mode", {26'b0, mode}, M_SHUF);
            measure(M_SHUF, len); check("shuf_len", len, 4);
            measure(M_IDLE, len); check("gap2_len", len, 1);
            check("decr_mode", {26'b0, mode}, M_DECR);
            measure(M_DECR, len); check("decr_len", len, 4);
            if (k < 2) begin
                // GAP3 + CHECK (bad byte at 5 -> 7 cycles) + NEXT
                measure(M_IDLE, len); check("reject_idle_len", len, 9);
            end else begin
                // GAP3 + CHECK over 32 bytes plus read latency
                wait_done(200, n); check("accept_latency", n, 34);
            end
        end
        check("win_done",  done, 1);
        check("win_found", found, 1);
        check("win_key",   key_flat, 24'h000002);
        check("win_busy",  busy, 0);
        check("win_mode",  {26'b0, mode}, M_IDLE);

        // Exhaust the key space (KEY_MAX=3) with no valid message.
        win_key = 24'hFFFFFF;
        pulse_start();
        check("restart_done",  done, 0);
        check("restart_found", found, 0);
        check("restart_busy",  busy, 1);
        check("restart_key",   key_flat, 0);
        check("restart_mode",  {26'b0, mode}, M_INIT);
        n = 0;
        while ((key_flat != 24'h1) && (n < 500)) begin n++; @(negedge clk); end
        check("reach_key1", (n < 500), 1);
        pulse_start();
        check("start_ignored_key",  key_flat, 24'h1);
        check("start_ignored_busy", busy, 1);
        wait_done(2000, n); check("exhaust_reached", done, 1);
        check("exhaust_found", found, 0);
        check("exhaust_key",   key_flat, 24'h000003);
        check("exhaust_busy",  busy, 0);
        check("exhaust_error", error, 0);

        // Asynchronous reset in the middle of SHUF for key 1.
        win_key = 24'h000002;
        pulse_start();
        n = 0;
        while (!((key_flat == 24'h1) && (mode == M_SHUF)) && (n < 500)) begin n++; @(negedge clk); end
        check("reach_shuf_key1", (n < 500), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_mode", {26'b0, mode}, M_IDLE);
        check("midrst_key",  key_flat, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        check("post_rst_key",  key_flat, 0);
        check("post_rst_mode", {26'b0, mode}, M_INIT);
        wait_done(2000, n);
        check("post_rst_found", found, 1);
        check("post_rst_wkey",  key_flat, 24'h000002);

`ifdef RC4_SEQ_TIMEOUT_EN
        // Decrypt never finishes: watchdog fires after 16 DECR cycles.
        decr_hang = 1'b1;
        pulse_start();
        n = 0;
        while ((mode != M_DECR) && (n < 200)) begin n++; @(negedge clk); end
        check("reach_decr", (n < 200), 1);
        measure(M_DECR, len); check("tmo_decr_len", len, 16);
        check("tmo_done",  done, 1);
        check("tmo_error", error, 1);
        check("tmo_found", found, 0);
        check("tmo_busy",  busy, 0);
        decr_hang = 1'b0;
`else
        check("error_tied_low", error, 0);
`endif

        check("mode_gap_violations", gap_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_key_sequencer.md
# rc4_key_sequencer

Master sequencer that drives the `mode` and `key` inputs of the RAM controller and consumes its `finish_bus`. It brute-forces the key space: each candidate runs S-RAM init, shuffle, then decrypt, and the decrypted message in result RAM is checked for plaintext validity. It sits above the RAM controller at the top of the decryption core and reports `done`, `found` and the winning key.

## Interface
- RAM_WIDTH, 8, byte width of all RAMs
- KEY_LENGTH, 3, key bytes
- NUM_DEVICES, 3, width of `finish_bus` (0 = init, 1 = shuffle, 2 = decrypt)
- MESSAGE_LOG_LENGTH, 5, result-RAM address width; message length is 2**MESSAGE_LOG_LENGTH bytes
- KEY_MAX, 24'h3FFFFF, last candidate tried
- TIMEOUT_CYCLES, 4096, per-phase watchdog limit (used only with the macro)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin search from key 0; honored only in IDLE or DONE
- mode  out  6  controller function select
- key  out  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  current candidate; key[KEY_LENGTH-1] is the most significant byte
- finish_bus  in  NUM_DEVICES  per-device finished flags
- rAddr  out  MESSAGE_LOG_LENGTH  result-RAM read address
- rOut  in  RAM_WIDTH  result-RAM read data, valid one cycle after rAddr
- busy  out  1  high from start until DONE
- done  out  1  search ended; held until next start
- found  out  1  valid when done; key holds the winning candidate
- error  out  1  watchdog abort

## Operation
- Mode codes: IDLE 6'b000_000, INIT 6'b001_000, SHUFFLE 6'b010_000, DECRYPT 6'b011_000.
- FSM: IDLE → INIT → GAP1 → SHUF → GAP2 → DECR → GAP3 → CHECK → NEXT → INIT | DONE. DONE → INIT on start.
- `mode` is registered and equals the code of the state being entered. It is IDLE in IDLE, all GAP states, CHECK, NEXT and DONE.
- Phase handshake: each run state sets an arm flag the first cycle its finish bit is sampled low. The state exits only when the bit is sampled high while armed. This prevents acting on a stale finish.
- Finish bits belonging to other phases are ignored.
- Each GAP state lasts exactly one cycle with mode IDLE, so the device sees its start drop.
- CHECK:
  - rAddr streams 0..2**MESSAGE_LOG_LENGTH-1, one address per cycle.
  - Each byte is valid iff it is 8'h20 or 8'h61–8'h7A.
  - On the first invalid byte, go to NEXT immediately; outstanding reads are discarded.
  - If all bytes are valid, go to DONE with found=1. Key is frozen.
- NEXT: if key == KEY_MAX, go to DONE with found=0. Otherwise key increments by 1 and the FSM enters INIT.
- start in DONE clears done, found and error, loads key=0 and enters INIT. start in any other non-IDLE state is ignored.
- Reset values: mode=IDLE, key=0, rAddr=0, busy=0, done=0, found=0, error=0, state IDLE.
- Reset mid-operation clears everything immediately (asynchronous). No partial completion is flagged.

## Timing
- start sampled high in IDLE → next edge: state INIT, mode=INIT, busy=1.
- Run phase lasts at least 2 cycles (arm, then finish).
- Finish sampled high → next edge: GAP (mode IDLE) → following edge: next run mode.
- CHECK, all valid: 2**MESSAGE_LOG_LENGTH + 1 cycles (one extra for read latency).
- CHECK, invalid byte at index n: n + 2 cycles.
- done and busy change on the same edge.
- found/error are valid whenever done=1.

## Configuration
- `RC4_SEQ_TIMEOUT_EN` defined:
  - A per-phase cycle counter clears on entry to INIT, SHUF or DECR.
  - Reaching TIMEOUT_CYCLES in a run state forces DONE with error=1, found=0 and mode=IDLE.
- Undefined: no counter is built, error is tied 0, and phases wait indefinitely.

## Structure
- Shared package `rc4_pkg`:
  - mode code localparams
  - state enum typedef
  - `is_plain_char` function
- One sub-module `msg_checker`:
  - owns rAddr streaming, the one-cycle data alignment and the validity test
  - handshake with the FSM: go in; pass/fail pulse out

## Test plan
- Ideal devices (finish 3 cycles after start), message valid at key 24'h000002 → keys 0, 1, 2 tried; done=1, found=1, key=24'h000002; mode returns to IDLE between every phase.
- finish_bus[0] held high from a prior run on INIT entry → sequencer waits for the low, then the high; no early exit.
- Invalid byte 8'h7B at index 5 → CHECK exits after 7 cycles; key increments.
- KEY_MAX=24'h000003, no valid message → done=1, found=0, key=24'h000003, busy=0.
- reset asserted mid-SHUF → mode=IDLE, key=0, busy=0 asynchronously; the next start restarts from key 0.
- With `RC4_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=16, decrypt never finishes → done=1, error=1 after 16 DECR cycles.
